// File: rtl/dsp_pkg.sv
// Shared types and constants for the DSP48E2 operand path: opcode enum, ALUMODE/OPMODE
// encodings, port widths and the operand bundle handed to the downstream ALU primitives.
package dsp_pkg;

  localparam int DSP_A_W = 30;
  localparam int DSP_B_W = 18;
  localparam int DSP_P_W = 48;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4
  } op_e;

  localparam logic [3:0] ALUMODE_ADD = 4'b0000;
  localparam logic [3:0] ALUMODE_SUB = 4'b0011;
  localparam logic [3:0] ALUMODE_AND = 4'b1100;
  localparam logic [3:0] ALUMODE_OR  = 4'b1100;
  localparam logic [3:0] ALUMODE_XOR = 4'b0100;

  // X=A:B, Z=C; the YONES variant forces Y to all ones, which turns the AND mode into OR.
  localparam logic [8:0] OPMODE_XZ       = 9'b000110011;
  localparam logic [8:0] OPMODE_XZ_YONES = 9'b000111011;

  typedef struct packed {
    logic [DSP_A_W-1:0] a30;
    logic [DSP_B_W-1:0] b18;
    logic [DSP_P_W-1:0] c48;
    logic [3:0]         alumode;
    logic [8:0]         opmode;
    logic               err;
  } dsp_operand_t;

  localparam int DSP_OPERAND_W = $bits(dsp_operand_t);

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/skid_reg.sv
// Two-entry skid buffer: main register M drives the outputs, skid register S catches the
// one extra beat that arrives while the output is stalled, so in_ready can stay a flop.
module skid_reg
  import dsp_pkg::*;
#(
  parameter int W = DSP_OPERAND_W
) (
  input  logic        clock,
  input  logic        reset,
  // valid/ready: a beat moves on a rising edge where valid and ready are both high; once
  // out_valid rises, out_data holds until out_ready is seen; in_ready depends on state only.
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [W-1:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [W-1:0] out_data,
  output skid_state_e state
);

  skid_state_e state_q, state_d;
  logic        ready_q, valid_q;
  logic [W-1:0] m_q, s_q;
  logic        in_xfer, out_xfer;
  logic        load_m, load_s, m_from_s;

  assign in_xfer  = in_valid & ready_q;
  assign out_xfer = valid_q & out_ready;

  // State register; ready/valid are re-registered from the next state so neither is a
  // combinational function of this cycle's handshake inputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= SKID_EMPTY;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != SKID_FULL);
      valid_q <= (state_d != SKID_EMPTY);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SKID_EMPTY: if (in_xfer) state_d = SKID_ONE;
      SKID_ONE: begin
        if (in_xfer && !out_xfer)      state_d = SKID_FULL;
        else if (!in_xfer && out_xfer) state_d = SKID_EMPTY;
      end
      SKID_FULL:  if (out_xfer) state_d = SKID_ONE;
      default:    state_d = SKID_EMPTY;
    endcase
  end

  always_comb begin
    load_m   = 1'b0;
    load_s   = 1'b0;
    m_from_s = 1'b0;
    case (state_q)
      SKID_EMPTY: load_m = in_xfer;
      SKID_ONE: begin
        load_m = in_xfer & out_xfer;
        load_s = in_xfer & ~out_xfer;
      end
      SKID_FULL: begin
        load_m   = out_xfer;
        m_from_s = 1'b1;
      end
      default: ;
    endcase
  end

  // Payload registers only move on their enables, so stale bits never reach the outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_q <= '0;
      s_q <= '0;
    end else begin
      if (load_m) m_q <= m_from_s ? s_q : in_data;
      if (load_s) s_q <= in_data;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_data  = m_q;
  assign state     = state_q;

endmodule

// File: rtl/dsp_operand_stage.sv
// Registered operand stage in front of the DSP48E2 ALU: extends both operands to 48 bits,
// splits b across the A:B ports, decodes the opcode to ALUMODE/OPMODE and skid-buffers it.
module dsp_operand_stage
  import dsp_pkg::*;
#(
  parameter int width    = 48,
  parameter bit sign_ext = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_op,
  input  logic [width-1:0]    in_a,
  input  logic [width-1:0]    in_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DSP_A_W-1:0]  out_dsp_a,
  output logic [DSP_B_W-1:0]  out_dsp_b,
  output logic [DSP_P_W-1:0]  out_dsp_c,
  output logic [3:0]          out_alumode,
  output logic [8:0]          out_opmode,
  output logic                out_err
);

  logic [DSP_P_W-1:0] a_ext, b_ext;
  dsp_operand_t       dec;
  dsp_operand_t       held;
  skid_state_e        skid_state;

  if (width < 1 || width > DSP_P_W) begin : g_bad_width
    $error("dsp_operand_stage: width must be in 1..48");
  end

  if (width == DSP_P_W) begin : g_no_ext
    assign a_ext = in_a;
    assign b_ext = in_b;
  end else begin : g_ext
    assign a_ext = {{(DSP_P_W - width){sign_ext & in_a[width-1]}}, in_a};
    assign b_ext = {{(DSP_P_W - width){sign_ext & in_b[width-1]}}, in_b};
  end

  // Illegal opcodes fall through as AND with err set; the data still passes unchanged.
  always_comb begin
    dec         = '0;
    dec.a30     = b_ext[DSP_P_W-1:DSP_B_W];
    dec.b18     = b_ext[DSP_B_W-1:0];
    dec.c48     = a_ext;
    dec.alumode = ALUMODE_AND;
    dec.opmode  = OPMODE_XZ;
    dec.err     = 1'b1;
    case (in_op)
      OP_ADD: begin
        dec.alumode = ALUMODE_ADD;
        dec.err     = 1'b0;
      end
      OP_SUB: begin
        dec.alumode = ALUMODE_SUB;
        dec.err     = 1'b0;
      end
      OP_AND: begin
        dec.alumode = ALUMODE_AND;
        dec.err     = 1'b0;
      end
      OP_OR: begin
        dec.alumode = ALUMODE_OR;
        dec.opmode  = OPMODE_XZ_YONES;
        dec.err     = 1'b0;
      end
      OP_XOR: begin
        dec.alumode = ALUMODE_XOR;
        dec.err     = 1'b0;
      end
      default: ;
    endcase
  end

  skid_reg #(
    .W(DSP_OPERAND_W)
  ) u_skid (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (dec),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (held),
    .state    (skid_state)
  );

  assign out_dsp_a   = held.a30;
  assign out_dsp_b   = held.b18;
  assign out_dsp_c   = held.c48;
  assign out_alumode = held.alumode;
  assign out_opmode  = held.opmode;
  assign out_err     = held.err;

  a_full_blocks_input: assert property (@(posedge clock) disable iff (reset)
    (skid_state == SKID_FULL) |-> !in_ready);

  a_stall_holds_output: assert property (@(posedge clock) disable iff (reset)
    (out_valid && !out_ready) |=> (out_valid && $stable(held)));

endmodule
